charli_keyscan: RTL and testbench
=================================

# charli_keyscan

Charlieplexed key scanner for the expansion board. It reads six diode-isolated push-buttons wired across three shared tri-state pins, which is the input counterpart of the charlieplexed LED driver. The block time-multiplexes a single low-driven pin, samples the other two through a synchronizer, debounces per key, and presents a stable 6-bit key state plus one-cycle press and release pulses to board-level logic.

## Interface
- `PHASE_CYCLES`, 16384: clocks per scan phase. Must be ≥ 4.
- `DEBOUNCE_FRAMES`, 4: consecutive disagreeing frames required to flip a key. Range 1..15.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `scan_en` in 1: high runs the scan. Low releases all pins and restarts the scan.
- `charli_pin` inout 3: matrix pins. External pull-ups are required. The block drives either `0` or `z`, never `1`.
- `key_state` out 6: debounced level per key, 1 = pressed.
- `key_press` out 6: one-cycle pulse on a 0→1 change of `key_state`.
- `key_release` out 6: one-cycle pulse on a 1→0 change of `key_state`.
- `frame_done` out 1: one-cycle pulse when a full 3-phase frame has been sampled.

## Operation
- **Phase counter.** `phase` cycles 0,1,2,0,… `cnt` runs 0..`PHASE_CYCLES`-1 within each phase.
- **Drive.** At `cnt`==0 all pins are `z`; this is the discharge guard. For `cnt`≥1, pin `phase` is driven `0` and the other two pins are `z`.
- **Synchronizer.** Each pin's input passes through its own 2-flop synchronizer.
- **Sampling.** At `cnt`==`PHASE_CYCLES`-1 the synchronized values of pins (`phase`+1)%3 and (`phase`+2)%3 are latched, inverted, into `raw[2*phase]` and `raw[2*phase+1]`. A low pin reads as pressed.
- **Key map.**
  - key0: pin0 low → sense pin1. key1: pin0 low → sense pin2.
  - key2: pin1 low → sense pin2. key3: pin1 low → sense pin0.
  - key4: pin2 low → sense pin0. key5: pin2 low → sense pin1.
- **Frame end.** The phase-2 sample completes the frame. `frame_done` pulses on the following cycle, and the debounce update happens on that same cycle.
- **Debounce, per key k** (4-bit `dcnt[k]`):
  - If `raw[k]` equals `key_state[k]`, `dcnt[k]` is cleared.
  - Otherwise `dcnt[k]` increments. When the incremented value reaches `DEBOUNCE_FRAMES`, `key_state[k]` toggles, `dcnt[k]` clears, and the matching press or release pulse fires.
- **`scan_en` low.**
  - Pins go `z` on the next cycle.
  - `phase`, `cnt` and the partial `raw` are cleared.
  - `key_state` and `dcnt` hold.
  - No pulses are produced.
  - When `scan_en` returns high, the scan restarts at `phase`=0, `cnt`=0, and a partial frame is never evaluated.
- **Simultaneous key changes.** Keys are independent; several keys may pulse in the same cycle.

## Timing
- **Reset values.** `key_state`=0, `key_press`=0, `key_release`=0, `frame_done`=0, all pins `z`, `phase`=0, `cnt`=0, `raw`=0, `dcnt`=0. Synchronizer flops reset to 1, meaning released.
- **Frame length.** 3·`PHASE_CYCLES` clocks.
- **Sampling point.** Each sample is taken `PHASE_CYCLES`-2 cycles after the drive starts. This gives ≥1 cycle settle plus 2 cycles of synchronizer latency.
- **Press latency.** From the start of the first frame whose samples all show the key pressed to the `key_press` pulse: (`DEBOUNCE_FRAMES`-1)·3·`PHASE_CYCLES` + 3·`PHASE_CYCLES` + 1 clocks.
- **Output registering.** `key_state` updates in the same cycle as its pulse. All outputs are registered.
- **`rst` during a scan.** All state returns to reset values on the next edge, and pins are `z` from that edge.
- **Wrap-around.** `cnt` wraps to 0 and `phase` advances; `phase` wraps 2→0 with no idle gap.

## Configuration
- Macro: `CHARLI_KEYSCAN_DEBOUNCE_EN`.
- **Defined.** Per-key debounce as described above.
- **Undefined.**
  - `DEBOUNCE_FRAMES` is ignored and `dcnt` is not built.
  - `key_state` loads `raw` directly on the `frame_done` cycle.
  - `key_press` = `raw` & ~`key_state` and `key_release` = ~`raw` & `key_state`, both evaluated on that cycle.

## Test plan
Parameters for all scenarios: `PHASE_CYCLES`=8, `DEBOUNCE_FRAMES`=2.

- **Reset/idle.** Assert `rst` 3 cycles, then `scan_en`=1 with all pins pulled high → pins `z` at `cnt`==0, pin0 driven 0 during cycles 1..7, `frame_done` every 24 cycles, `key_state`=0, no pulses.
- **Single press.** Model key3 by pulling pin0 low whenever pin1 is driven low → `key_press`=6'b001000 for exactly one cycle, 49 cycles after the first full pressed frame starts; `key_state`=6'b001000.
- **Glitch rejection.** Key3 pressed for one frame only → no pulse, `key_state` unchanged.
- **Release and multi-key.** Press key0 and key5, then release both → `key_press`=6'b100001 in one cycle, later `key_release`=6'b100001 in one cycle.
- **Scan abort.** Drop `scan_en` at cycle 13 of a frame and restart → pins `z` the next cycle, the next `frame_done` comes 24+1 cycles after restart, and `key_state` is held throughout.
- **Macro off.** Single frame with key1 pressed → `key_press`=6'b000010 on the first `frame_done` cycle.

Source files
------------

// File: rtl/charli_keyscan_if.sv
// Key-scanner control/status bundle between board logic and charli_keyscan.
interface charli_keyscan_if;
  logic       scan_en;
  logic [5:0] key_state;
  logic [5:0] key_press;
  logic [5:0] key_release;
  logic       frame_done;

  modport master (
    output scan_en,
    input  key_state, key_press, key_release, frame_done
  );

  modport slave (
    input  scan_en,
    output key_state, key_press, key_release, frame_done
  );
endinterface

// File: rtl/charli_keyscan.sv
// Charlieplexed 6-key scanner over 3 open-drain pins.
// CHARLI_KEYSCAN_DEBOUNCE_EN enables per-key frame debounce.
module charli_keyscan #(
  parameter int PHASE_CYCLES    = 16384,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst,
  inout  wire  [2:0]      charli_pin,
  charli_keyscan_if.slave bus
);
  localparam int            CW       = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

  if (PHASE_CYCLES < 4 || DEBOUNCE_FRAMES < 1 ||
      DEBOUNCE_FRAMES > 15) begin : g_cfg_chk
    $error("charli_keyscan: parameter out of range");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    drv_q, drv_d;
  logic [2:0]    sync1_q, sync2_q;
  logic [5:0]    raw_q, raw_d;
  logic          eval_q, eval_d;
  logic [5:0]    state_q, state_d;
  logic [5:0]    press_q, press_d;
  logic [5:0]    rel_q, rel_d;
  logic          done_q, done_d;
  logic          last;

  // Open-drain: only ever pull low.
  for (genvar i = 0; i < 3; i++) begin : g_pin
    assign charli_pin[i] = drv_q[i] ? 1'b0 : 1'bz;
  end

  always_comb begin
    last    = (cnt_q == CNT_LAST);
    cnt_d   = last ? '0 : cnt_q + CW'(1);
    phase_d = phase_q;
    raw_d   = raw_q;
    eval_d  = last && (phase_q == 2'd2);
    if (last) begin
      phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
      unique case (phase_q)
        2'd0:    raw_d[1:0] = ~{sync2_q[2], sync2_q[1]};
        2'd1:    raw_d[3:2] = ~{sync2_q[0], sync2_q[2]};
        default: raw_d[5:4] = ~{sync2_q[1], sync2_q[0]};
      endcase
    end
    if (!bus.scan_en) begin
      cnt_d   = '0;
      phase_d = 2'd0;
      raw_d   = '0;
      eval_d  = 1'b0;
    end
    // cnt==0 of every phase is the all-release discharge guard.
    drv_d = (cnt_d != '0) ? (3'b001 << phase_d) : 3'b000;
  end

  assign done_d = eval_q && bus.scan_en;

`ifdef CHARLI_KEYSCAN_DEBOUNCE_EN
  localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_FRAMES);

  logic [5:0][3:0] dcnt_q, dcnt_d;
  logic [3:0]      inc;

  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    dcnt_d  = dcnt_q;
    inc     = '0;
    if (done_d) begin
      for (int k = 0; k < 6; k++) begin
        inc = dcnt_q[k] + 4'd1;
        if (raw_q[k] == state_q[k]) begin
          dcnt_d[k] = '0;
        end else if (inc == DB_LIM) begin
          state_d[k] = ~state_q[k];
          press_d[k] = ~state_q[k];
          rel_d[k]   = state_q[k];
          dcnt_d[k]  = '0;
        end else begin
          dcnt_d[k] = inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dcnt_q <= '0;
    else     dcnt_q <= dcnt_d;
  end
`else
  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    if (done_d) begin
      state_d = raw_q;
      press_d = raw_q & ~state_q;
      rel_d   = ~raw_q & state_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
      drv_q   <= 3'b000;
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      raw_q   <= '0;
      eval_q  <= 1'b0;
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      drv_q   <= drv_d;
      sync1_q <= charli_pin;
      sync2_q <= sync1_q;
      raw_q   <= raw_d;
      eval_q  <= eval_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      done_q  <= done_d;
    end
  end

  assign bus.key_state   = state_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;
  assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_charli_keyscan.sv
// Directed scoreboard bench for charli_keyscan.
// Builds with or without CHARLI_KEYSCAN_DEBOUNCE_EN.
module tb_charli_keyscan;
  localparam int PC    = 8;
  localparam int DB    = 2;
  localparam int FRAME = 3 * PC;
`ifdef CHARLI_KEYSCAN_DEBOUNCE_EN
  localparam int DEFF = DB;
`else
  localparam int DEFF = 1;
`endif

  typedef struct packed {
    logic [5:0]  st;
    logic [5:0]  pr;
    logic [5:0]  rl;
    logic [23:0] dc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [2:0]  pin;
  logic [2:0]  tb_pull = 3'b000;
  logic [2:0]  pull_d;
  logic [5:0]  keys = 6'b0;
  exp_t        q[$];
  logic [5:0]  m_st = 6'b0;
  logic [23:0] m_dc = 24'b0;
  int          vecs = 0;
  int          errs = 0;
  int          n;
  int          tot;

  charli_keyscan_if bus ();

  charli_keyscan #(
    .PHASE_CYCLES    (PC),
    .DEBOUNCE_FRAMES (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .charli_pin (pin),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_pu
    pullup pu (pin[i]);
    assign pin[i] = tb_pull[i] ? 1'b0 : 1'bz;
  end

  // Key k: DUT pulls pin k/2 low, the diode drags the sense pin low.
  always_comb begin
    pull_d = 3'b000;
    for (int k = 0; k < 6; k++)
      if (keys[k] && pin[k/2] == 1'b0 && !tb_pull[k/2])
        pull_d[(k/2 + 1 + k%2) % 3] = 1'b1;
  end

  always @(negedge clk) tb_pull <= pull_d;

  function automatic exp_t model(input logic [5:0] raw,
                                 input logic [5:0] st,
                                 input logic [23:0] dc);
    exp_t e;
    e.st = st;
    e.pr = '0;
    e.rl = '0;
    e.dc = dc;
`ifdef CHARLI_KEYSCAN_DEBOUNCE_EN
    for (int k = 0; k < 6; k++) begin
      if (raw[k] == st[k]) begin
        e.dc[4*k +: 4] = '0;
      end else if (int'(dc[4*k +: 4]) + 1 >= DB) begin
        e.st[k] = raw[k];
        e.pr[k] = raw[k];
        e.rl[k] = ~raw[k];
        e.dc[4*k +: 4] = '0;
      end else begin
        e.dc[4*k +: 4] = dc[4*k +: 4] + 4'd1;
      end
    end
`else
    e.st = raw;
    e.pr = raw & ~st;
    e.rl = ~raw & st;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [5:0] m, input string tag,
                           output int cyc);
    exp_t e;
    logic stray;
    keys = m;
    q.push_back(model(m, m_st, m_dc));
    cyc   = 0;
    stray = 1'b0;
    do begin
      step();
      cyc++;
      if (!bus.frame_done && (bus.key_press != 0 || bus.key_release != 0))
        stray = 1'b1;
    end while (!bus.frame_done && cyc < 4 * FRAME);
    e = q.pop_front();
    chk({tag, "/done"},  32'(bus.frame_done),  32'd1);
    chk({tag, "/state"}, 32'(bus.key_state),   32'(e.st));
    chk({tag, "/press"}, 32'(bus.key_press),   32'(e.pr));
    chk({tag, "/rel"},   32'(bus.key_release), 32'(e.rl));
    chk({tag, "/stray"}, 32'(stray),           32'd0);
    m_st = e.st;
    m_dc = e.dc;
  endtask

  initial begin
    bus.scan_en = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_state", 32'(bus.key_state),   32'd0);
    chk("rst_press", 32'(bus.key_press),   32'd0);
    chk("rst_rel",   32'(bus.key_release), 32'd0);
    chk("rst_done",  32'(bus.frame_done),  32'd0);
    chk("rst_pin",   32'(pin),             32'b111);

    rst = 1'b0;
    bus.scan_en = 1'b1;
    run_frame(6'b0, "idle0", n);
    chk("idle0_lat", n, FRAME + 1);
    chk("pin_p0c1", 32'(pin), 32'b110);
    repeat (6) step();
    chk("pin_p0c7", 32'(pin), 32'b110);
    step();
    chk("pin_p1c0", 32'(pin), 32'b111);
    step();
    chk("pin_p1c1", 32'(pin), 32'b101);
    run_frame(6'b0, "idle1", n);
    run_frame(6'b0, "idle2", n);
    chk("frame_period", n, FRAME);

    // first pressed frame starts one cycle before the mask change
    tot = 0;
    for (int i = 0; i < DEFF; i++) begin
      run_frame(6'b001000, "press3", n);
      tot += n;
    end
    chk("press3_lat", tot, (DEFF - 1) * FRAME + FRAME + 1 - 1);
    chk("press3_val", 32'(bus.key_press), 32'b001000);
    step();
    chk("press3_1cyc", 32'(bus.key_press), 32'd0);

    repeat (11) step();
    chk("abort_pin_pre", 32'(pin), 32'b100);
    bus.scan_en = 1'b0;
    step();
    chk("abort_pin1_z", 32'(pin[1]), 32'd1);
    chk("abort_nopulse", 32'(bus.key_press | bus.key_release), 32'd0);
    repeat (4) step();
    chk("abort_hold", 32'(bus.key_state), 32'b001000);
    chk("abort_nodone", 32'(bus.frame_done), 32'd0);
    bus.scan_en = 1'b1;
    run_frame(6'b001000, "restart", n);
    chk("restart_lat", n, FRAME + 1);

    for (int i = 0; i < DEFF; i++) run_frame(6'b0, "rel3", n);

    run_frame(6'b001000, "glitch", n);
    run_frame(6'b0, "glitch_a", n);
    run_frame(6'b0, "glitch_b", n);

    for (int i = 0; i < DEFF; i++) run_frame(6'b100001, "multi_p", n);
    chk("multi_press", 32'(bus.key_press), 32'b100001);
    for (int i = 0; i < DEFF; i++) run_frame(6'b0, "multi_r", n);
    chk("multi_rel", 32'(bus.key_release), 32'b100001);

    run_frame(6'b000010, "key1", n);
`ifndef CHARLI_KEYSCAN_DEBOUNCE_EN
    chk("key1_direct", 32'(bus.key_press), 32'b000010);
`endif
    run_frame(6'b0, "key1_a", n);
    run_frame(6'b0, "key1_b", n);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
